packet_switch: RTL and testbench
================================

// Module: packet_switch
// PURPOSE
//  Two-way address-based packet switch. Each valid input beat (addr, data) is
//  steered to output port A when addr <= ADDR_DIV, otherwise to port B.
//  Sits between a single upstream producer and two downstream consumers.
//  Outputs are registered, so a beat appears one clock after it is accepted.
// PARAMETERS
//  ADDR_WIDTH  8      width of addr, addr_a, addr_b
//  DATA_WIDTH  16     width of data, data_a, data_b
//  ADDR_DIV    8'h3F  highest address routed to port A (inclusive)
// PORTS
//  clk     in   1           single clock; all logic on posedge
//  rstn    in   1           reset; synchronous, active-low
//  vld     in   1           input beat valid this cycle
//  addr    in   ADDR_WIDTH  input destination address
//  data    in   DATA_WIDTH  input payload
//  addr_a  out  ADDR_WIDTH  port A address (registered)
//  data_a  out  DATA_WIDTH  port A payload (registered)
//  addr_b  out  ADDR_WIDTH  port B address (registered)
//  data_b  out  DATA_WIDTH  port B payload (registered)
// BEHAVIOUR
//  - Reset: one clock, synchronous and active-low, named clk/rstn. On a posedge
//    with rstn=0, all four outputs become 0. Reset overrides vld.
//  - Latency: exactly 1 cycle. A beat sampled at posedge N is visible on the
//    outputs after posedge N.
//  - vld=1 and addr <= ADDR_DIV (unsigned compare):
//    addr_a<=addr, data_a<=data, addr_b<=0, data_b<=0.
//  - vld=1 and addr > ADDR_DIV:
//    addr_b<=addr, data_b<=data, addr_a<=0, data_a<=0.
//  - vld=0: all outputs hold their previous values. There is no output valid;
//    a downstream consumer treats a nonzero addr or data as a beat.
//  - Boundaries:
//    - addr == ADDR_DIV goes to A; addr == ADDR_DIV+1 goes to B.
//    - addr == 0 goes to A.
//    - addr all-ones goes to B.
//  - Back-to-back beats: one beat per cycle, with no stall or backpressure.
//    Alternating A/B beats zero the opposite port each cycle.
//  - Reset mid-stream: a beat presented in the same cycle that rstn is low is
//    dropped. Outputs are 0 on the next cycle.
//  - X or unknown on vld is not supported. Inputs are assumed synchronous to clk.
// STRUCTURE
//  - Shared package switch_pkg holds:
//    - the ADDR_WIDTH and DATA_WIDTH defaults and ADDR_DIV;
//    - typedef addr_t (logic [ADDR_WIDTH-1:0]);
//    - typedef data_t (logic [DATA_WIDTH-1:0]);
//    - the struct pkt_t {addr_t addr; data_t data;} shared by the bench.
//  - One sub-module, switch_port_reg: a synchronous-reset output register with
//    load/clear/hold controls. It is instantiated twice (A and B).
//  - Route decode (addr <= ADDR_DIV) is combinational in the top level.
//  - The bench interface switch_if carries rstn, vld, addr, data and the four
//    outputs, clocked by clk.
// TESTING
//  1. Reset: set rstn=0 for 1 cycle with vld=1, addr=8'h10, data=16'hBEEF.
//     Required: all outputs are 0 after that edge.
//  2. Port A: send vld=1, addr=8'h22, data=16'h1234.
//     Required next cycle: addr_a=8'h22, data_a=16'h1234, addr_b=0, data_b=0.
//  3. Port B: send vld=1, addr=8'h80, data=16'hCAFE.
//     Required next cycle: addr_b=8'h80, data_b=16'hCAFE, addr_a=0, data_a=0.
//  4. Boundary: send addr=8'h3F, then 8'h40, back to back.
//     Required: the 3F beat appears on A, then the 40 beat appears on B with A
//     cleared.
//  5. Hold: after case 3, drive vld=0 with addr=8'h01, data=16'hFFFF for
//     3 cycles. Required: outputs stay at B=80/CAFE.
//  6. Random: 200 beats with random vld, addr and data. A scoreboard predicts
//     port and value, and checks every cycle against a reference model.

Source files
------------

// File: rtl/switch_pkg.sv
// Shared widths, routing split point and beat types for the two-way packet switch.
package switch_pkg;

    localparam int unsigned DEF_ADDR_WIDTH = 8;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam logic [DEF_ADDR_WIDTH-1:0] DEF_ADDR_DIV = 8'h3F;

    typedef logic [DEF_ADDR_WIDTH-1:0] addr_t;
    typedef logic [DEF_DATA_WIDTH-1:0] data_t;

    typedef struct packed {
        addr_t addr;
        data_t data;
    } pkt_t;

endpackage

// File: rtl/switch_if.sv
// Bundle of the switch's control, input beat and output port signals, clocked by clk.
interface switch_if
    import switch_pkg::*;
(
    input logic clk
);
    logic  rstn;
    logic  vld;
    addr_t addr;
    data_t data;
    addr_t addr_a;
    data_t data_a;
    addr_t addr_b;
    data_t data_b;
endinterface

// File: rtl/switch_port_reg.sv
// Output port register with synchronous active-low reset; load wins over clear, else hold.
module switch_port_reg #(
    parameter int unsigned WIDTH = 24
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d, q_q;

    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = d;
        end else if (clear) begin
            q_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/packet_switch.sv
// Two-way address-based switch: beats with addr <= ADDR_DIV go to port A, others to port B.
module packet_switch
    import switch_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] ADDR_DIV = DEF_ADDR_DIV
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  vld,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [ADDR_WIDTH-1:0] addr_a,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [ADDR_WIDTH-1:0] addr_b,
    output logic [DATA_WIDTH-1:0] data_b
);

    localparam int unsigned BEAT_WIDTH = ADDR_WIDTH + DATA_WIDTH;

    logic                  route_a;
    logic                  load_a, load_b;
    logic [BEAT_WIDTH-1:0] beat;
    logic [BEAT_WIDTH-1:0] q_a, q_b;

    // A beat loads its own port and zeroes the other, so only one port shows it.
    always_comb begin
        route_a = (addr <= ADDR_DIV);
        load_a  = vld & route_a;
        load_b  = vld & ~route_a;
        beat    = {addr, data};
    end

    switch_port_reg #(
        .WIDTH (BEAT_WIDTH)
    ) u_port_a (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load_a),
        .clear (load_b),
        .d     (beat),
        .q     (q_a)
    );

    switch_port_reg #(
        .WIDTH (BEAT_WIDTH)
    ) u_port_b (
        .clk   (clk),
        .rstn  (rstn),
        .load  (load_b),
        .clear (load_a),
        .d     (beat),
        .q     (q_b)
    );

    assign {addr_a, data_a} = q_a;
    assign {addr_b, data_b} = q_b;

endmodule

// File: tb/tb_packet_switch.sv
// Directed and randomised self-checking bench for packet_switch.
module tb_packet_switch;
    import switch_pkg::*;

    localparam int unsigned OW = 2 * (DEF_ADDR_WIDTH + DEF_DATA_WIDTH);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    switch_if sif (.clk(clk));

    packet_switch dut (
        .clk    (clk),
        .rstn   (sif.rstn),
        .vld    (sif.vld),
        .addr   (sif.addr),
        .data   (sif.data),
        .addr_a (sif.addr_a),
        .data_a (sif.data_a),
        .addr_b (sif.addr_b),
        .data_b (sif.data_b)
    );

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] got;
    logic [OW-1:0] exp;

    // Present one input beat, clock it in, and land 1 time unit after the edge.
    task automatic drive(input logic r, input logic v, input addr_t a, input data_t d);
        sif.rstn = r;
        sif.vld  = v;
        sif.addr = a;
        sif.data = d;
        @(posedge clk);
        #1;
        got = {sif.addr_a, sif.data_a, sif.addr_b, sif.data_b};
    endtask

    task automatic test_reset();
        drive(1'b0, 1'b1, 8'h10, 16'hBEEF);
        exp = '0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_port_a();
        drive(1'b1, 1'b1, 8'h22, 16'h1234);
        exp = {8'h22, 16'h1234, 8'h00, 16'h0000};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL port_a: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_port_b();
        drive(1'b1, 1'b1, 8'h80, 16'hCAFE);
        exp = {8'h00, 16'h0000, 8'h80, 16'hCAFE};
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL port_b: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_hold();
        exp = {8'h00, 16'h0000, 8'h80, 16'hCAFE};
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h01, 16'hFFFF);
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL hold[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_boundary();
        addr_t a_tab [4] = '{8'h3F, 8'h40, 8'h00, 8'hFF};
        data_t d_tab [4] = '{16'h0A3F, 16'h0B40, 16'h0A00, 16'h0BFF};
        logic [OW-1:0] e_tab [4] = '{
            {8'h3F, 16'h0A3F, 8'h00, 16'h0000},
            {8'h00, 16'h0000, 8'h40, 16'h0B40},
            {8'h00, 16'h0A00, 8'h00, 16'h0000},
            {8'h00, 16'h0000, 8'hFF, 16'h0BFF}
        };
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, a_tab[i], d_tab[i]);
            exp = e_tab[i];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL boundary addr=%h: got %h expected %h", a_tab[i], got, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        addr_t a_tab [4] = '{8'h05, 8'hC0, 8'h3E, 8'h41};
        data_t d_tab [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        logic [OW-1:0] e_tab [4] = '{
            {8'h05, 16'h1111, 8'h00, 16'h0000},
            {8'h00, 16'h0000, 8'hC0, 16'h2222},
            {8'h3E, 16'h3333, 8'h00, 16'h0000},
            {8'h00, 16'h0000, 8'h41, 16'h4444}
        };
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, a_tab[i], d_tab[i]);
            exp = e_tab[i];
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h expected %h", i, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        drive(1'b1, 1'b1, 8'h90, 16'h5555);
        drive(1'b0, 1'b1, 8'h12, 16'h6666);
        exp = '0;
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_stream: got %h expected %h", got, exp);
        end
        drive(1'b1, 1'b0, 8'h12, 16'h6666);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL reset_mid_stream_hold: got %h expected %h", got, exp);
        end
    endtask

    task automatic test_random();
        addr_t m_addr_a, m_addr_b;
        data_t m_data_a, m_data_b;
        logic  r, v;
        addr_t a;
        data_t d;
        m_addr_a = '0;
        m_data_a = '0;
        m_addr_b = '0;
        m_data_b = '0;
        for (int i = 0; i < 200; i++) begin
            r = (i == 0) ? 1'b0 : ($urandom_range(0, 15) != 0);
            v = 1'($urandom_range(0, 1));
            a = addr_t'($urandom_range(0, 255));
            d = data_t'($urandom_range(0, 65535));
            if (!r) begin
                m_addr_a = '0;
                m_data_a = '0;
                m_addr_b = '0;
                m_data_b = '0;
            end else if (v && a <= 8'h3F) begin
                m_addr_a = a;
                m_data_a = d;
                m_addr_b = '0;
                m_data_b = '0;
            end else if (v) begin
                m_addr_a = '0;
                m_data_a = '0;
                m_addr_b = a;
                m_data_b = d;
            end
            drive(r, v, a, d);
            exp = {m_addr_a, m_data_a, m_addr_b, m_data_b};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL random[%0d] r=%b v=%b addr=%h data=%h: got %h expected %h",
                         i, r, v, a, d, got, exp);
            end
        end
    endtask

    initial begin
        sif.rstn = 1'b1;
        sif.vld  = 1'b0;
        sif.addr = '0;
        sif.data = '0;
        #2;
        test_reset();
        test_port_a();
        test_port_b();
        test_hold();
        test_boundary();
        test_back_to_back();
        test_reset_mid_stream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
